// File: rtl/add_4_unit.sv
// add_4_unit: registered 4-bit ripple-carry adder with carry-in/carry-out.
// {c_o, s_o} = x_i + y_i + c_i, presented one clock after the operands are sampled.
// Optional feature: define ADD_4_UNIT_OVF_EN to add the registered
// two's-complement overflow flag ovf_o (ovf = c[4] ^ c[3]).
module add_4_unit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
`ifdef ADD_4_UNIT_OVF_EN
  ,
  output logic       ovf_o
`endif
);

  logic [4:0] w_c;   // carry chain, w_c[0] = carry-in, w_c[4] = carry-out
  logic [3:0] w_s;   // combinational sum bits
  logic [3:0] r_s;
  logic       r_c;

  // Ripple-carry chain of four full-adder cells
  always_comb begin
    w_c    = '0;
    w_s    = '0;
    w_c[0] = c_i;
    for (int unsigned k = 0; k < 4; k++) begin
      w_s[k]   = x_i[k] ^ y_i[k] ^ w_c[k];
      w_c[k+1] = (x_i[k] & y_i[k]) | (w_c[k] & (x_i[k] ^ y_i[k]));
    end
  end

  // Output registers: capture the sum every edge, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s <= '0;
      r_c <= 1'b0;
    end else begin
      r_s <= w_s;
      r_c <= w_c[4];
    end
  end

  assign s_o = r_s;
  assign c_o = r_c;

`ifdef ADD_4_UNIT_OVF_EN
  logic w_ovf;
  logic r_ovf;

  assign w_ovf = w_c[4] ^ w_c[3];

  // Overflow register shares latency and reset with the sum
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_ovf <= 1'b0;
    else       r_ovf <= w_ovf;
  end

  assign ovf_o = r_ovf;
`endif

endmodule

// File: tb/tb_add_4_unit.sv
// tb_add_4_unit: randomized and directed bench for add_4_unit with an
// arithmetic reference model. Builds with or without ADD_4_UNIT_OVF_EN.
module tb_add_4_unit;

  logic       clk;
  logic       rst;
  logic [3:0] x;
  logic [3:0] y;
  logic       ci;
  logic [3:0] s_o;
  logic       c_o;
  logic       dut_ovf;

`ifdef ADD_4_UNIT_OVF_EN
  localparam bit OVF = 1'b1;
  add_4_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .x_i   (x),
    .y_i   (y),
    .c_i   (ci),
    .s_o   (s_o),
    .c_o   (c_o),
    .ovf_o (dut_ovf)
  );
`else
  localparam bit OVF = 1'b0;
  assign dut_ovf = 1'b0;
  add_4_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .x_i   (x),
    .y_i   (y),
    .c_i   (ci),
    .s_o   (s_o),
    .c_o   (c_o)
  );
`endif

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the last sampled operands
  bit       model_valid = 1'b0;
  bit [3:0] m_s;
  bit       m_c;
  bit       m_ovf;

  always @(posedge clk or posedge rst) begin
    int usum, sx, sy, ssum;
    if (rst) begin
      m_s = 4'd0; m_c = 1'b0; m_ovf = 1'b0;
    end else begin
      usum  = int'(x) + int'(y) + int'(ci);
      sx    = (x >= 4'd8) ? int'(x) - 16 : int'(x);
      sy    = (y >= 4'd8) ? int'(y) - 16 : int'(y);
      ssum  = sx + sy + int'(ci);
      m_s   = usum[3:0];
      m_c   = (usum >= 16);
      m_ovf = OVF & ((ssum > 7) || (ssum < -8));
    end
    model_valid = 1'b1;
  end

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ovf/c/s=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] lit(input bit ovf, input bit c, input bit [3:0] s);
    return {ovf & OVF, c, s};
  endfunction

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin
    if (model_valid)
      chk("stream", {dut_ovf, c_o, s_o}, {m_ovf, m_c, m_s});
  end

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
    @(posedge clk);
    #2;
    x = a; y = b; ci = c;
  endtask

  task automatic expect_next(input string name, input logic [5:0] exp);
    @(posedge clk);
    #1;
    chk(name, {dut_ovf, c_o, s_o}, exp);
  endtask

  initial begin
    rst = 1'b0;
    x = 4'hF; y = 4'hF; ci = 1'b1;

    // Reset: outputs clear immediately and stay clear across edges
    @(posedge clk); #3;
    rst = 1'b1;
    #1 chk("reset_async", {dut_ovf, c_o, s_o}, 6'd0);
    expect_next("reset_hold1", 6'd0);
    expect_next("reset_hold2", 6'd0);
    #2 rst = 1'b0;

    // Directed sums, each checked one edge after being applied
    drive(4'b0101, 4'b0111, 1'b0); expect_next("sum_5_7",   lit(1'b1, 1'b0, 4'b1100));
    drive(4'b1101, 4'b0111, 1'b0); expect_next("sum_13_7",  lit(1'b0, 1'b1, 4'b0100));
    drive(4'b1101, 4'b0110, 1'b0); expect_next("sum_13_6",  lit(1'b0, 1'b1, 4'b0011));
    drive(4'b1111, 4'b0000, 1'b1); expect_next("ripple",    lit(1'b0, 1'b1, 4'b0000));
    drive(4'b1111, 4'b1111, 1'b1); expect_next("max_31",    lit(1'b0, 1'b1, 4'b1111));

    // Input changes between edges must not reach the outputs
    for (int i = 0; i < 8; i++) begin
      drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      @(posedge clk); #1;
      #3 x = 4'($urandom_range(15)); y = 4'($urandom_range(15)); ci = 1'($urandom_range(1));
      #1 chk("between_edges", {dut_ovf, c_o, s_o}, {m_ovf, m_c, m_s});
    end

    // Random stream, one new operand set per cycle
    for (int i = 0; i < 200; i++)
      drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));

    // Reset mid-stream: in-flight result discarded, next edge captures normally
    drive(4'b1001, 4'b1001, 1'b0);
    expect_next("pre_reset", lit(1'b1, 1'b1, 4'b0010));
    #2 rst = 1'b1;
    #1 chk("midreset_async", {dut_ovf, c_o, s_o}, 6'd0);
    #2 rst = 1'b0;
    expect_next("post_reset", lit(1'b1, 1'b1, 4'b0010));

    // Exhaustive sweep of all x, y, c_i combinations
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      drive(v[3:0], v[7:4], v[8]);
    end
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
